regfile_wb_queue: RTL and testbench
===================================

// Module: regfile_wb_queue
// PURPOSE
//  Write-side front end of the 32x32 register file: owns its single write port (wr/addr/data).
//  Merges the in-order pipeline writeback (port A, never stalls) with results from long-latency
//  units (port B, valid/ready), buffering B in a DEPTH-entry FIFO.
//  Keeps a per-register pending scoreboard so decode can stall on registers still awaiting a B result.
// PARAMETERS
//  DEPTH  4   B-side FIFO entries; power of two, >=2
//  DW     32  data width
//  AW     5   register address width ($0..$31)
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-low; clears all state
//  a_wr       in   1        pipeline writeback request, always accepted
//  a_addr     in   AW       pipeline destination register
//  a_data     in   DW       pipeline result
//  b_valid    in   1        long-latency result valid
//  b_addr     in   AW       long-latency destination register
//  b_data     in   DW       long-latency result
//  b_ready    out  1        FIFO can accept; = ~full
//  rf_wr      out  1        register-file write enable (registered)
//  rf_addr    out  AW       register-file write address (registered)
//  rf_data    out  DW       register-file write data (registered)
//  mark_en    in   1        decode issued a B-class op; set pending[mark_addr]
//  mark_addr  in   AW       register to mark pending
//  chk_addr1  in   AW       decode source 1 to check
//  chk_addr2  in   AW       decode source 2 to check
//  busy1      out  1        pending[chk_addr1] (combinational; 0 for $0)
//  busy2      out  1        pending[chk_addr2] (combinational; 0 for $0)
//  fifo_cnt   out  clog2(DEPTH)+1  FIFO occupancy
//  err        out  1        sticky error; exists only with WBQ_ERR_CHK_EN
// BEHAVIOUR
//  - Reset: rf_wr=0, rf_addr=0, rf_data=0, FIFO empty (fifo_cnt=0, b_ready=1), pending all 0, err=0.
//    Reset mid-operation discards FIFO contents and the scoreboard.
//  - Push: b_valid&&b_ready at the edge writes {b_addr,b_data} at the tail.
//    b_ready depends only on full: no push when full, even if a pop happens in the same cycle.
//  - Output selection, per edge (latency 1):
//      a_wr=1: rf_* <= {1,a_addr,a_data}; FIFO does not pop.
//      a_wr=0 and FIFO not empty: pop head; rf_* <= {1,head.addr,head.data}.
//      otherwise: rf_wr <= 0; rf_addr/rf_data hold their values.
//  - A has strict priority. No starvation guard: B drains only in cycles with a_wr=0.
//  - $0 target: A write presents rf_wr=0. A B head with addr 0 is popped with rf_wr=0 and
//    clears no pending bit.
//  - Push and pop in the same cycle: occupancy unchanged. Pointers wrap modulo DEPTH.
//  - Scoreboard: a pop of a B entry with addr r!=0 clears pending[r] at the same edge it loads
//    rf_*. mark_en with mark_addr!=0 sets pending[mark_addr].
//    Set and clear of the same register in one cycle: set wins.
//  - busy is cleared the cycle rf_wr is presented, so a read in that cycle still returns the old
//    value. Decode therefore also treats (rf_wr && rf_addr==chk) as a hazard.
//  - Ordering: B results for the same register retire in push order. No A/B ordering is enforced
//    for the same register; the issuer guarantees it by stalling on busy.
// CONFIGURATION
//  WBQ_ERR_CHK_EN defined: err port present. err sets (sticky until reset) on either:
//    - mark_en to a register already pending without a same-cycle clear, or
//    - a pop of a B entry whose addr!=0 and whose pending bit is 0.
//  WBQ_ERR_CHK_EN undefined: no err port or logic. Behaviour otherwise identical.
// TESTING
//  1 Reset, then idle: rf_wr=0, b_ready=1, fifo_cnt=0, busy1=busy2=0 for all chk addrs.
//  2 a_wr=1, a_addr=8, a_data=32'h1234 for 1 cycle -> next cycle rf_wr=1, rf_addr=8, rf_data=32'h1234;
//    following cycle rf_wr=0.
//  3 mark r2; push B{2,32'hAA} while a_wr=1 for 3 cycles -> entry held, busy(2)=1;
//    first a_wr=0 cycle -> rf_wr=1, rf_addr=2, rf_data=32'hAA, busy(2)=0.
//  4 a_wr=1 continuously; push 5 B entries -> b_ready=0 after 4th, fifo_cnt=4, 5th held;
//    drop a_wr -> entries written in push order, one per cycle.
//  5 push B{0,x} with a_wr=0 -> popped, rf_wr=0, no pending bit changes.
//  6 Assert reset with fifo_cnt=3 and pending(5)=1 -> rf_wr=0, fifo_cnt=0, busy(5)=0 immediately.
//    With WBQ_ERR_CHK_EN: mark r5 twice -> err=1 and held.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// regfile_wb_queue
//
// Write-side front end of the 32x32 register file. Owns the single write
// port (rf_wr / rf_addr / rf_data) and merges two result sources onto it:
//   - port A: in-order pipeline writeback, never stalls, strict priority
//   - port B: long-latency results, buffered in a DEPTH-entry FIFO
// A per-register pending scoreboard lets decode stall on registers that
// are still waiting for a B result.
//
// Optional feature macro: WBQ_ERR_CHK_EN
//   defined   -> sticky 'err' output flags scoreboard misuse
//   undefined -> no err port and no err logic
//
// Handshake: on port B a beat transfers at a rising clk edge when
//   b_valid && b_ready. b_ready depends only on FIFO fullness (never on
//   a same-cycle pop), and b_valid must not depend on b_ready.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low; clears all state
//   a_wr/a_addr/a_data   pipeline writeback (always accepted)
//   b_valid/b_addr/b_data/b_ready   long-latency result handshake
//   rf_wr/rf_addr/rf_data   registered register-file write port
//   mark_en/mark_addr       set pending bit for an issued B-class op
//   chk_addr1/chk_addr2     decode source registers to check
//   busy1/busy2             pending bit of the checked registers ($0 -> 0)
//   fifo_cnt                FIFO occupancy
//   err                     sticky error (WBQ_ERR_CHK_EN only)
// ---------------------------------------------------------------------------
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_wr,
    input  logic [AW-1:0]            a_addr,
    input  logic [DW-1:0]            a_data,
    input  logic                     b_valid,
    input  logic [AW-1:0]            b_addr,
    input  logic [DW-1:0]            b_data,
    output logic                     b_ready,
    output logic                     rf_wr,
    output logic [AW-1:0]            rf_addr,
    output logic [DW-1:0]            rf_data,
    input  logic                     mark_en,
    input  logic [AW-1:0]            mark_addr,
    input  logic [AW-1:0]            chk_addr1,
    input  logic [AW-1:0]            chk_addr2,
    output logic                     busy1,
    output logic                     busy2,
    output logic [$clog2(DEPTH):0]   fifo_cnt
`ifdef WBQ_ERR_CHK_EN
    ,
    output logic                     err
`endif
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << AW;

    // FIFO storage and pointers (pointers wrap naturally: DEPTH is 2**PW)
    logic [AW-1:0]   r_fifo_addr [DEPTH];
    logic [DW-1:0]   r_fifo_data [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_cnt;

    // Registered write port
    logic            r_rf_wr;
    logic [AW-1:0]   r_rf_addr;
    logic [DW-1:0]   r_rf_data;

    // Pending scoreboard, one bit per architectural register
    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_nxt;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [AW-1:0]   w_head_addr;
    logic [DW-1:0]   w_head_data;
    logic            w_pend_clr;
    logic            w_mark_set;

    assign w_full      = (r_cnt == CW'(DEPTH));
    assign w_empty     = (r_cnt == '0);
    assign w_push      = b_valid && !w_full;
    // B only drains in cycles where A is idle
    assign w_pop       = !a_wr && !w_empty;
    assign w_head_addr = r_fifo_addr[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];
    assign w_pend_clr  = w_pop && (w_head_addr != '0);
    assign w_mark_set  = mark_en && (mark_addr != '0);

    // Storage is not reset: contents are only observed through r_cnt/r_rptr
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= b_addr;
            r_fifo_data[r_wptr] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Output selection: A wins, else pop the FIFO head, else idle (hold addr/data).
    // Writes targeting $0 are presented with rf_wr low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rf_wr   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else if (a_wr) begin
            r_rf_wr   <= (a_addr != '0);
            r_rf_addr <= a_addr;
            r_rf_data <= a_data;
        end else if (w_pop) begin
            r_rf_wr   <= (w_head_addr != '0);
            r_rf_addr <= w_head_addr;
            r_rf_data <= w_head_data;
        end else begin
            r_rf_wr   <= 1'b0;
        end
    end

    // Clear applied first so that a same-cycle mark of the same register wins
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_pend_clr) w_pend_nxt[w_head_addr] = 1'b0;
        if (w_mark_set) w_pend_nxt[mark_addr]   = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

`ifdef WBQ_ERR_CHK_EN
    logic r_err;
    logic w_err_mark;
    logic w_err_pop;

    // Double mark is only an error if the register is not retiring this cycle
    assign w_err_mark = w_mark_set && r_pend[mark_addr] &&
                        !(w_pend_clr && (w_head_addr == mark_addr));
    assign w_err_pop  = w_pend_clr && !r_pend[w_head_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_err_mark || w_err_pop) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign b_ready  = !w_full;
    assign rf_wr    = r_rf_wr;
    assign rf_addr  = r_rf_addr;
    assign rf_data  = r_rf_data;
    assign fifo_cnt = r_cnt;
    assign busy1    = (chk_addr1 != '0) && r_pend[chk_addr1];
    assign busy2    = (chk_addr2 != '0) && r_pend[chk_addr2];

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Testbench for regfile_wb_queue: directed scenarios plus random traffic,
// checked against a queue/array reference model of the write-port merge.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CW    = 3;
  // expected entry: {addr_data_known, rf_wr, rf_addr, rf_data}
  localparam int W     = 2 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          a_wr = 0, b_valid = 0, mark_en = 0;
  logic [AW-1:0] a_addr = 0, b_addr = 0, mark_addr = 0, chk_addr1 = 0, chk_addr2 = 0;
  logic [DW-1:0] a_data = 0, b_data = 0;
  logic          b_ready, rf_wr, busy1, busy2;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [CW-1:0] fifo_cnt;
`ifdef WBQ_ERR_CHK_EN
  logic          err;
`endif

  regfile_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .a_wr(a_wr), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data),
    .mark_en(mark_en), .mark_addr(mark_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .busy1(busy1), .busy2(busy2), .fifo_cnt(fifo_cnt)
`ifdef WBQ_ERR_CHK_EN
    , .err(err)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            pend[32];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_known;

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    m_addr  = '0;
    m_data  = '0;
    m_known = 1;
  endtask

  // Drive one cycle's inputs (called just after a falling edge), check the
  // combinational outputs against the model, then advance the model to what
  // the next rising edge must produce.
  task automatic apply(input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input logic me, input logic [AW-1:0] ma,
                       input logic [AW-1:0] c1, input logic [AW-1:0] c2);
    bit   push_ok, wr;
    ent_t h, n;
    a_wr = aw; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    mark_en = me; mark_addr = ma;
    chk_addr1 = c1; chk_addr2 = c2;
    #1;
    check("b_ready", 32'(b_ready), 32'(mq.size() < DEPTH));
    check("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
    check("busy1", 32'(busy1), 32'(c1 != 0 && pend[c1]));
    check("busy2", 32'(busy2), 32'(c2 != 0 && pend[c2]));
    push_ok = bv && (mq.size() < DEPTH);
    wr = 0;
    if (aw) begin
      wr = (aa != 0);
      m_addr = aa; m_data = ad; m_known = wr;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      wr = (h.a != 0);
      if (h.a != 0) pend[h.a] = 0;
      m_addr = h.a; m_data = h.d; m_known = wr;
    end
    if (me && ma != 0) pend[ma] = 1;
    if (push_ok) begin
      n.a = ba; n.d = bd;
      mq.push_back(n);
    end
    exp_q.push_back({m_known, wr, m_addr, m_data});
  endtask

  task automatic step(input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic me, input logic [AW-1:0] ma,
                      input logic [AW-1:0] c1, input logic [AW-1:0] c2);
    @(negedge clk);
    apply(aw, aa, ad, bv, ba, bd, me, ma, c1, c2);
  endtask

  task automatic idle(input int n, input logic [AW-1:0] c1);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, c1, 0);
  endtask

  // Assert reset at a falling edge, check reset values right away, release.
  task automatic do_reset(input logic [AW-1:0] c1);
    @(negedge clk);
    reset = 0;
    a_wr = 0; b_valid = 0; mark_en = 0;
    chk_addr1 = c1; chk_addr2 = 0;
    model_reset();
    #1;
    check("rst_rf_wr", 32'(rf_wr), 0);
    check("rst_rf_addr", 32'(rf_addr), 0);
    check("rst_rf_data", rf_data, 0);
    check("rst_fifo_cnt", 32'(fifo_cnt), 0);
    check("rst_b_ready", 32'(b_ready), 1);
    check("rst_busy1", 32'(busy1), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    apply(0, 0, 0, 0, 0, 0, 0, 0, c1, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rf_wr", 32'(rf_wr), 32'(e[W-2]));
        if (e[W-1]) begin
          check("rf_addr", 32'(rf_addr), 32'(e[AW+DW-1:DW]));
          check("rf_data", rf_data, e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic bv, aw, me;
    model_reset();
    // 1: reset state, busy low for every register
    #1;
    check("init_rf_wr", 32'(rf_wr), 0);
    check("init_b_ready", 32'(b_ready), 1);
    check("init_fifo_cnt", 32'(fifo_cnt), 0);
    for (int i = 0; i < 32; i++) begin
      chk_addr1 = AW'(i); chk_addr2 = AW'(31 - i);
      #1;
      check("init_busy1", 32'(busy1), 0);
      check("init_busy2", 32'(busy2), 0);
    end
    @(negedge clk);
    reset = 1;
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0);

    // 2: single A write then idle
    step(1, 8, 32'h1234, 0, 0, 0, 0, 0, 8, 0);
    idle(2, 8);

    // 3: B entry held behind A, then retired
    step(0, 0, 0, 0, 0, 0, 1, 2, 2, 0);
    step(1, 9, 32'h11, 1, 2, 32'hAA, 0, 0, 2, 0);
    step(1, 10, 32'h22, 0, 0, 0, 0, 0, 2, 0);
    step(1, 11, 32'h33, 0, 0, 0, 0, 0, 2, 0);
    idle(3, 2);

    // 4: fill FIFO under continuous A, fifth push refused, drain in order
    for (int i = 0; i < 6; i++)
      step(1, AW'(12 + i), DW'(32'h100 + i), 1, AW'(20 + i), DW'(32'hB00 + i), 0, 0, 20, 21);
    idle(6, 20);

    // 5: B entry to $0
    step(0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 0);
    idle(3, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      aw = ($urandom_range(0, 99) < 45);
      bv = ($urandom_range(0, 99) < 55);
      me = ($urandom_range(0, 99) < 25);
      step(aw, AW'($urandom_range(0, 31)), $urandom,
           bv, AW'($urandom_range(0, 31)), $urandom,
           me, AW'($urandom_range(0, 31)),
           AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
    end
    idle(6, 0);

    // 6: reset with 3 entries queued and r5 pending
    step(1, 3, 32'h1, 0, 0, 0, 1, 5, 5, 0);
    step(1, 3, 32'h2, 1, 5, 32'h55, 0, 0, 5, 0);
    step(1, 3, 32'h3, 1, 6, 32'h66, 0, 0, 5, 0);
    step(1, 3, 32'h4, 1, 7, 32'h77, 0, 0, 5, 0);
    @(negedge clk);
    #1;
    check("pre_rst_cnt", 32'(fifo_cnt), 3);
    check("pre_rst_busy5", 32'(busy1), 1);
    do_reset(5);
    idle(2, 5);

`ifdef WBQ_ERR_CHK_EN
    check("err_after_reset", 32'(err), 0);
    step(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    idle(1, 5);
    check("err_set", 32'(err), 1);
    idle(2, 5);
    check("err_held", 32'(err), 1);
`endif

    // let the last expectations drain, bounded
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
